edge_event_arbiter: RTL

Multi-channel edge-event controller that shares a single event output port among CH asynchronous input lines. Each channel is synchronised and edge-detected according to a per-channel mode, and the detected event is held as pending. A round-robin scheduler then serialises pending events onto one valid/ready event stream carrying channel index and polarity. The block sits between raw external pins and the event-consuming logic, and replaces per-pin edge detectors with one sequenced resource.

---
 rtl/edge_event_arbiter.sv | 83 ++++++++
 1 files changed

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: synchronises CH async lines, detects mode-selected edges and round-robins them onto one valid/ready event stream
// Ports: clock/rst (async active-high); din raw lines; mode 2 bits per channel (00 off, 01 rise, 10 fall, 11 both);
//        evt_valid/evt_ready/evt_ch/evt_rise output event slot; ovf sticky per-channel overflow; ovf_clr clears ovf.
module edge_event_arbiter #(
  parameter int CH = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CHW = $clog2(CH)
) (
  input  logic            clock,
  input  logic            rst,
  input  logic [CH-1:0]   din,
  input  logic [2*CH-1:0] mode,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [CHW-1:0]  evt_ch,
  output logic            evt_rise,
  output logic [CH-1:0]   ovf,
  input  logic            ovf_clr
);
  localparam int AW = $clog2(SYNC_STAGES + 2);
  localparam logic [CHW:0] CHN = (CHW+1)'(CH);
  localparam logic [CHW-1:0] LAST = CHW'(CH - 1);
  logic [SYNC_STAGES-1:0][CH-1:0] sync_q;
  logic [CH-1:0] prev_q, pend_q, pend_d, pol_q, pol_d, ovf_q, ovf_d, s, edg, qual, take;
  logic [AW-1:0] arm_q, arm_d;
  logic [CHW-1:0] ptr_q, ptr_d, win, ch_q, ch_d;
  logic valid_q, valid_d, rise_q, rise_d, load, grant;
  logic [CHW:0] sum;
  always_comb begin
    s = sync_q[SYNC_STAGES-1];
    edg = s ^ prev_q;
    arm_d = arm_q == '0 ? arm_q : arm_q - AW'(1);
    for (int i = 0; i < CH; i++)
      qual[i] = (arm_q == '0) & edg[i] & (s[i] ? mode[2*i] : mode[2*i+1]);
    // downward scan so the pending channel closest above the pointer is assigned last
    win = ptr_q;
    sum = '0;
    for (int j = CH - 1; j >= 0; j--) begin
      sum = {1'b0, ptr_q} + (CHW+1)'(j);
      sum = sum >= CHN ? sum - CHN : sum;
      if (pend_q[sum[CHW-1:0]]) win = sum[CHW-1:0];
    end
    load = ~valid_q | evt_ready;
    grant = load & |pend_q;
    take = grant ? CH'(1) << win : '0;
    pend_d = qual | (pend_q & ~take);
    ovf_d = (qual & pend_q & ~take) | (ovf_q & {CH{~ovf_clr}});
    for (int i = 0; i < CH; i++)
      pol_d[i] = qual[i] & (~pend_q[i] | take[i]) ? s[i] : pol_q[i];
    valid_d = load ? |pend_q : valid_q;
    ch_d = grant ? win : ch_q;
    rise_d = grant ? pol_q[win] : rise_q;
    ptr_d = grant ? (win == LAST ? '0 : win + CHW'(1)) : ptr_q;
  end
  always_ff @(posedge clock or posedge rst)
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
      pend_q <= '0;
      pol_q <= '0;
      ovf_q <= '0;
      arm_q <= AW'(SYNC_STAGES + 1);
      ptr_q <= '0;
      ch_q <= '0;
      valid_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= s;
      pend_q <= pend_d;
      pol_q <= pol_d;
      ovf_q <= ovf_d;
      arm_q <= arm_d;
      ptr_q <= ptr_d;
      ch_q <= ch_d;
      valid_q <= valid_d;
      rise_q <= rise_d;
    end
  assign evt_valid = valid_q;
  assign evt_ch = ch_q;
  assign evt_rise = rise_q;
  assign ovf = ovf_q;
endmodule
